// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - shared state encoding and segment constants for seg7_scan
package seg7_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - scan strobe, display data and pin-side signals of seg7_scan
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic                  tick;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic                  load;
    logic                  lz_blank;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp_n;
    logic                  frame;

    modport master (
        output tick, data, dp, load, lz_blank,
        input  an, seg, dp_n, frame
    );

    modport slave (
        input  tick, data, dp, load, lz_blank,
        output an, seg, dp_n, frame
    );
endinterface

// File: rtl/seg7_scan_hex2seg.sv
// rtl/seg7_scan_hex2seg.sv - combinational hex nibble to active-low segment decoder
module hex2seg
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_HEX[nib];
endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 7-segment scan driver with dead time and leading-zero blanking
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DWELL_TICKS = 4,
    parameter int DEAD_TICKS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int MAXT = max_int(DWELL_TICKS, DEAD_TICKS);
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int IW   = $clog2(DIGITS);
    localparam int DW   = 4 * DIGITS;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            first, first_n;
    logic            frame_n;
    logic [DW-1:0]   hold_data, disp_data, disp_data_n;
    logic [DIGITS-1:0] hold_dp, disp_dp, disp_dp_n;

    logic [3:0]        nib;
    logic [6:0]        hex_seg;
    logic [DIGITS-1:0] nz;
    logic              lz_hide;

    // first marks the post-reset entry to digit 0, which copies disp without advancing idx
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        first_n     = first;
        frame_n     = 1'b0;
        disp_data_n = disp_data;
        disp_dp_n   = disp_dp;
        if (bus.tick) begin
            if (state == ST_BLANK) begin
                if (cnt == CW'(DEAD_TICKS - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_DRIVE;
                    if (first || idx == IW'(DIGITS - 1)) begin
                        idx_n       = '0;
                        disp_data_n = hold_data;
                        disp_dp_n   = hold_dp;
                        frame_n     = 1'b1;
                        first_n     = 1'b0;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end else begin
                if (cnt == CW'(DWELL_TICKS - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_BLANK;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        end
    end

    assign nib = disp_data_n[{idx_n, 2'b00} +: 4];

    hex2seg u_hex2seg (
        .nib (nib),
        .seg (hex_seg)
    );

    // nz[i] is set when nibble i or any more-significant nibble is non-zero
    always_comb begin
        logic acc;
        nz  = '0;
        acc = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc   = acc | (|disp_data_n[4*i +: 4]);
            nz[i] = acc;
        end
    end

    assign lz_hide = bus.lz_blank && (idx_n != '0) && !nz[idx_n];

    // Outputs are registered from next-state values so pins change with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_BLANK;
            idx       <= '0;
            cnt       <= '0;
            first     <= 1'b1;
            hold_data <= '0;
            hold_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            bus.an    <= '1;
            bus.seg   <= SEG_BLANK;
            bus.dp_n  <= 1'b1;
            bus.frame <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            first     <= first_n;
            disp_data <= disp_data_n;
            disp_dp   <= disp_dp_n;
            if (bus.load) begin
                hold_data <= bus.data;
                hold_dp   <= bus.dp;
            end
            bus.frame <= frame_n;
            if (state_n == ST_DRIVE) begin
                bus.an   <= ~(DIGITS'(1) << idx_n);
                bus.seg  <= lz_hide ? SEG_BLANK : hex_seg;
                bus.dp_n <= ~disp_dp_n[idx_n];
            end else begin
                bus.an   <= '1;
                bus.seg  <= SEG_BLANK;
                bus.dp_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized bench for seg7_scan against a tick-count reference model
module tb_seg7_scan;
    localparam int DIGITS = 4;
    localparam int DW0 = 1, DD0 = 1;
    localparam int DW1 = 2, DD1 = 3;

    logic        clk = 1'b0;
    logic        rst, tick, load, lz_blank;
    logic [15:0] data;
    logic [3:0]  dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_if #(.DIGITS(DIGITS)) if_a ();
    seg7_scan_if #(.DIGITS(DIGITS)) if_b ();

    assign if_a.tick = tick;  assign if_b.tick = tick;
    assign if_a.data = data;  assign if_b.data = data;
    assign if_a.dp   = dp;    assign if_b.dp   = dp;
    assign if_a.load = load;  assign if_b.load = load;
    assign if_a.lz_blank = lz_blank;  assign if_b.lz_blank = lz_blank;

    seg7_scan #(.DIGITS(DIGITS), .DWELL_TICKS(DW0), .DEAD_TICKS(DD0)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave));
    seg7_scan #(.DIGITS(DIGITS), .DWELL_TICKS(DW1), .DEAD_TICKS(DD1)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex_pat(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Display contents as a function of ticks seen since reset
    function automatic void model_out(input int n, input int dw, input int dd,
                                      input logic [15:0] dsp, input logic [3:0] dpv,
                                      input logic lz, output logic [3:0] an_e,
                                      output logic [6:0] seg_e, output logic dpn_e);
        int m, d;
        an_e = 4'hF; seg_e = 7'h7F; dpn_e = 1'b1;
        if (n >= dd) begin
            m = n - dd;
            if (m % (dw + dd) < dw) begin
                d = (m / (dw + dd)) % DIGITS;
                an_e  = ~(4'b0001 << d);
                dpn_e = ~dpv[d];
                if (lz && d > 0 && (dsp >> (4 * d)) == 16'h0) seg_e = 7'h7F;
                else seg_e = hex_pat(4'(dsp >> (4 * d)));
            end
        end
    endfunction

    int          n_t [2];
    logic [15:0] disp_m [2];
    logic [3:0]  disp_dp_m [2];
    logic [15:0] hold_m;
    logic [3:0]  hold_dp_m;
    logic [3:0]  e_an [2];
    logic [6:0]  e_seg [2];
    logic        e_dpn [2];
    logic        e_frame [2];

    initial begin
        hold_m = '0; hold_dp_m = '0;
        for (int k = 0; k < 2; k++) begin
            n_t[k] = 0; disp_m[k] = '0; disp_dp_m[k] = '0;
            e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dpn[k] = 1'b1; e_frame[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                hold_m = '0; hold_dp_m = '0;
                for (int k = 0; k < 2; k++) begin
                    n_t[k] = 0; disp_m[k] = '0; disp_dp_m[k] = '0;
                    e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dpn[k] = 1'b1; e_frame[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    int dw, dd;
                    dw = (k == 0) ? DW0 : DW1;
                    dd = (k == 0) ? DD0 : DD1;
                    e_frame[k] = 1'b0;
                    if (tick) begin
                        n_t[k]++;
                        if (n_t[k] >= dd && (n_t[k] - dd) % (DIGITS * (dw + dd)) == 0) begin
                            disp_m[k] = hold_m; disp_dp_m[k] = hold_dp_m; e_frame[k] = 1'b1;
                        end
                    end
                    model_out(n_t[k], dw, dd, disp_m[k], disp_dp_m[k], lz_blank,
                              e_an[k], e_seg[k], e_dpn[k]);
                end
                if (load) begin
                    hold_m = data; hold_dp_m = dp;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("an_a",    32'(if_a.an),    32'(e_an[0]));
            check("seg_a",   32'(if_a.seg),   32'(e_seg[0]));
            check("dp_n_a",  32'(if_a.dp_n),  32'(e_dpn[0]));
            check("frame_a", 32'(if_a.frame), 32'(e_frame[0]));
            check("an_b",    32'(if_b.an),    32'(e_an[1]));
            check("seg_b",   32'(if_b.seg),   32'(e_seg[1]));
            check("dp_n_b",  32'(if_b.dp_n),  32'(e_dpn[1]));
            check("frame_b", 32'(if_b.frame), 32'(e_frame[1]));
            check("onecold_a", 32'($countones(~if_a.an) <= 1), 32'd1);
            check("onecold_b", 32'($countones(~if_b.an) <= 1), 32'd1);
        end
    end

    task automatic run(input int ncyc, input int period);
        for (int i = 0; i < ncyc; i++) begin
            tick = (i % period == 0);
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    task automatic load_now(input logic [15:0] d, input logic [3:0] p);
        data = d; dp = p; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        bit hit;
        rst = 1'b1; tick = 1'b1; load = 1'b0; lz_blank = 1'b0; data = '0; dp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; tick = 1'b0;

        load_now(16'h12AF, 4'b0100);
        run(80, 4);

        lz_blank = 1'b1;
        load_now(16'h0005, 4'b0000);
        run(80, 4);
        lz_blank = 1'b0;
        run(64, 4);

        run(20, 4);
        load_now(16'h1111, 4'b0000);
        run(80, 4);

        hit = 0;
        for (int i = 0; i < 200; i++) begin
            int pred;
            pred = n_t[0] + 1;
            if (pred >= DD0 && (pred - DD0) % (DIGITS * (DW0 + DD0)) == 0) begin
                data = 16'hBEEF; dp = 4'b1001; load = 1'b1; tick = 1'b1;
                @(negedge clk);
                load = 1'b0; tick = 1'b0;
                hit = 1;
                break;
            end
            tick = 1'b1;
            @(negedge clk);
        end
        check("frame_load_found", 32'(hit), 32'd1);
        run(80, 4);

        hit = 0;
        for (int i = 0; i < 400; i++) begin
            if (e_an[0] == 4'b1011) begin
                rst = 1'b1; tick = 1'b1;
                @(negedge clk);
                rst = 1'b0; tick = 1'b0;
                hit = 1;
                break;
            end
            tick = (i % 4 == 0);
            @(negedge clk);
        end
        check("mid_reset_found", 32'(hit), 32'd1);
        run(100, 4);

        for (int i = 0; i < 4000; i++) begin
            tick = ($urandom_range(0, 2) == 0);
            load = ($urandom_range(0, 15) == 0);
            if (load) begin
                data = 16'($urandom);
                dp   = 4'($urandom);
            end
            if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
            rst = ($urandom_range(0, 799) == 0);
            @(negedge clk);
        end
        rst = 1'b0; tick = 1'b0; load = 1'b0;
        run(20, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
